// File: rtl/dds_pkg.sv
// Shared DDS definitions: sweep FSM encoding and default word widths,
// also used by sine_dds_lut users.
package dds_pkg;

    localparam int DDS_PHASE_WIDTH = 18;
    localparam int DDS_DWELL_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } dds_state_t;

endpackage

// File: rtl/dds_phase_accum.sv
// Phase accumulator: register plus adder with clear-to-zero and advance.
// Wraps naturally modulo 2^PHASE_WIDTH.
module dds_phase_accum
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = DDS_PHASE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_advance,
    input  logic [PHASE_WIDTH-1:0] i_freq,
    output logic [PHASE_WIDTH-1:0] o_phase
);

    logic [PHASE_WIDTH-1:0] r_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (i_clear) begin
            r_phase <= '0;
        end else if (i_advance) begin
            r_phase <= r_phase + i_freq;
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/sine_dds_sweep_ctrl.sv
// Chirp sequencer: steps a phase increment from start to stop with a
// programmable dwell and streams the resulting phase words to the LUT.
module sine_dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = DDS_PHASE_WIDTH,
    parameter int DWELL_WIDTH = DDS_DWELL_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PHASE_WIDTH-1:0] cfg_start_freq,
    input  logic [PHASE_WIDTH-1:0] cfg_stop_freq,
    input  logic [PHASE_WIDTH-1:0] cfg_freq_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_continuous,
    input  logic                   cmd_start,
    input  logic                   cmd_stop,
    output logic [PHASE_WIDTH-1:0] output_phase_tdata,
    output logic                   output_phase_tvalid,
    input  logic                   output_phase_tready,
    output logic                   output_phase_tlast,
    output logic                   busy,
    output logic                   done
);

    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

    dds_state_t r_state;
    dds_state_t w_state_nxt;
    logic       w_done_nxt;
    logic       r_done;

    logic [PHASE_WIDTH-1:0] r_start;
    logic [PHASE_WIDTH-1:0] r_stop;
    logic [PHASE_WIDTH-1:0] r_step;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic                   r_cont;
    logic [PHASE_WIDTH-1:0] r_freq;
    logic [DWELL_WIDTH-1:0] r_cnt;

    logic                   w_active;
    logic                   w_acc;
    logic                   w_start_ok;
    logic                   w_step_end;
    logic                   w_last;
    logic [PHASE_WIDTH:0]   w_sum;
    logic [PHASE_WIDTH-1:0] w_phase;

    assign w_active   = (r_state != ST_IDLE);
    assign w_acc      = w_active && output_phase_tready;
    // A start in the done cycle is ignored so restart needs one idle cycle.
    assign w_start_ok = (r_state == ST_IDLE) && cmd_start && !r_done;
    assign w_step_end = (r_cnt == (r_dwell - DWELL_ONE));
    assign w_sum      = {1'b0, r_freq} + {1'b0, r_step};
    // Wide compare covers both overflow past stop and adder carry-out.
    assign w_last     = w_step_end && (w_sum > {1'b0, r_stop});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_acc && (cmd_stop || (w_last && !r_cont))) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (cmd_stop) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_acc) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start <= '0;
            r_stop  <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_cont  <= 1'b0;
            r_freq  <= '0;
            r_cnt   <= '0;
        end else if (w_start_ok) begin
            r_start <= cfg_start_freq;
            r_stop  <= cfg_stop_freq;
            r_step  <= cfg_freq_step;
            r_dwell <= (cfg_dwell == '0) ? DWELL_ONE : cfg_dwell;
            r_cont  <= cfg_continuous;
            r_freq  <= cfg_start_freq;
            r_cnt   <= '0;
        end else if ((r_state == ST_RUN) && w_acc) begin
            if (w_step_end) begin
                r_cnt <= '0;
                if (w_last) begin
                    r_freq <= r_start;
                end else begin
                    r_freq <= w_sum[PHASE_WIDTH-1:0];
                end
            end else begin
                r_cnt <= r_cnt + DWELL_ONE;
            end
        end
    end

    dds_phase_accum #(
        .PHASE_WIDTH(PHASE_WIDTH)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_start_ok),
        .i_advance(w_acc),
        .i_freq   (r_freq),
        .o_phase  (w_phase)
    );

    assign output_phase_tdata  = w_phase;
    assign output_phase_tvalid = w_active;
    assign output_phase_tlast  = w_active && w_last;
    assign busy                = w_active;
    assign done                = r_done;

endmodule

// File: tb/tb_sine_dds_sweep_ctrl.sv
// Directed bench for sine_dds_sweep_ctrl: sweep, wrap, backpressure,
// continuous mode, abort, carry and reset scenarios.
module tb_sine_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] cfg_start_freq;
    logic [17:0] cfg_stop_freq;
    logic [17:0] cfg_freq_step;
    logic [15:0] cfg_dwell;
    logic        cfg_continuous;
    logic        cmd_start;
    logic        cmd_stop;
    logic [17:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    sine_dds_sweep_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_start_freq     (cfg_start_freq),
        .cfg_stop_freq      (cfg_stop_freq),
        .cfg_freq_step      (cfg_freq_step),
        .cfg_dwell          (cfg_dwell),
        .cfg_continuous     (cfg_continuous),
        .cmd_start          (cmd_start),
        .cmd_stop           (cmd_stop),
        .output_phase_tdata (tdata),
        .output_phase_tvalid(tvalid),
        .output_phase_tready(tready),
        .output_phase_tlast (tlast),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        cmd_start      = 1'b0;
        cmd_stop       = 1'b0;
        tready         = 1'b0;
        cfg_start_freq = '0;
        cfg_stop_freq  = '0;
        cfg_freq_step  = '0;
        cfg_dwell      = '0;
        cfg_continuous = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_sweep(input logic [17:0] s, input logic [17:0] p,
                               input logic [17:0] st, input logic [15:0] d,
                               input logic c);
        cfg_start_freq = s;
        cfg_stop_freq  = p;
        cfg_freq_step  = st;
        cfg_dwell      = d;
        cfg_continuous = c;
        cmd_start      = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 18'd0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: valid=%b last=%b data=%0d busy=%b done=%b, expected all 0",
                     tvalid, tlast, tdata, busy, done);
        end
    endtask

    task automatic test_sweep();
        int   exp_d[6];
        logic el;
        exp_d = '{0, 1000, 2000, 4000, 6000, 9000};
        do_reset();
        tready = 1'b1;
        start_sweep(18'd1000, 18'd3000, 18'd1000, 16'd2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            el = (i == 5);
            n_tests++;
            if (tvalid !== 1'b1 || tdata !== 18'(exp_d[i]) || tlast !== el ||
                busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep beat%0d: valid=%b data=%0d last=%b busy=%b done=%b, expected 1 %0d %b 1 0",
                         i, tvalid, tdata, tlast, busy, done, exp_d[i], el);
            end
            tick();
        end
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_end: done=%b busy=%b valid=%b, expected 1 0 0",
                     done, busy, tvalid);
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_done_pulse: done=%b, expected 0", done);
        end
    endtask

    task automatic test_wrap();
        logic [17:0] exp_d[4];
        logic        el;
        exp_d = '{18'h00000, 18'h30000, 18'h20000, 18'h10000};
        do_reset();
        tready = 1'b1;
        start_sweep(18'h30000, 18'h30000, 18'h00100, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            el = (i == 3);
            n_tests++;
            if (tvalid !== 1'b1 || tdata !== exp_d[i] || tlast !== el) begin
                n_fail++;
                $display("FAIL wrap beat%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                         i, tvalid, tdata, tlast, exp_d[i], el);
            end
            tick();
        end
        n_tests++;
        if (done !== 1'b1 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_end: done=%b valid=%b, expected 1 0", done, tvalid);
        end
    endtask

    task automatic test_backpressure();
        int          exp_d[6];
        int          k;
        int          idx;
        logic        pv;
        logic        pr;
        logic [17:0] pd;
        logic        pl;
        logic        el;
        exp_d = '{0, 1000, 2000, 4000, 6000, 9000};
        k = 0;
        idx = 0;
        pv = 1'b0;
        pr = 1'b1;
        pd = '0;
        pl = 1'b0;
        do_reset();
        start_sweep(18'd1000, 18'd3000, 18'd1000, 16'd2, 1'b0);
        while (idx < 6 && k < 60) begin
            if (pv && !pr) begin
                n_tests++;
                if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin
                    n_fail++;
                    $display("FAIL bp_stall cyc%0d: valid=%b data=%0d last=%b, expected 1 %0d %b",
                             k, tvalid, tdata, tlast, pd, pl);
                end
            end
            tready = (k % 4 == 0) || (k % 4 == 3);
            if (tvalid === 1'b1 && tready) begin
                el = (idx == 5);
                n_tests++;
                if (tdata !== 18'(exp_d[idx]) || tlast !== el) begin
                    n_fail++;
                    $display("FAIL bp beat%0d: data=%0d last=%b, expected %0d %b",
                             idx, tdata, tlast, exp_d[idx], el);
                end
                idx++;
            end
            pv = tvalid;
            pr = tready;
            pd = tdata;
            pl = tlast;
            k++;
            tick();
        end
        n_tests++;
        if (idx != 6) begin
            n_fail++;
            $display("FAIL bp_timeout: beats=%0d, expected 6", idx);
        end
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: done=%b busy=%b, expected 1 0", done, busy);
        end
    endtask

    task automatic test_continuous();
        int   exp_d[10];
        logic el;
        exp_d = '{0, 1000, 2000, 4000, 6000, 9000, 12000, 13000, 14000, 16000};
        do_reset();
        tready = 1'b1;
        start_sweep(18'd1000, 18'd3000, 18'd1000, 16'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            el = (i == 5);
            n_tests++;
            if (tvalid !== 1'b1 || tdata !== 18'(exp_d[i]) || tlast !== el ||
                done !== 1'b0) begin
                n_fail++;
                $display("FAIL cont beat%0d: valid=%b data=%0d last=%b done=%b, expected 1 %0d %b 0",
                         i, tvalid, tdata, tlast, done, exp_d[i], el);
            end
            tick();
        end
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        n_tests++;
        if (tvalid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_stop: valid=%b done=%b busy=%b, expected 0 1 0",
                     tvalid, done, busy);
        end
    endtask

    task automatic test_abort();
        do_reset();
        tready = 1'b1;
        start_sweep(18'd1000, 18'd3000, 18'd1000, 16'd2, 1'b0);
        tick();
        tick();
        tready = 1'b0;
        n_tests++;
        if (tvalid !== 1'b1 || tdata !== 18'd2000) begin
            n_fail++;
            $display("FAIL abort_pre: valid=%b data=%0d, expected 1 2000", tvalid, tdata);
        end
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (tvalid !== 1'b1 || tdata !== 18'd2000 || busy !== 1'b1 ||
                done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_hold%0d: valid=%b data=%0d busy=%b done=%b, expected 1 2000 1 0",
                         i, tvalid, tdata, busy, done);
            end
            tick();
        end
        tready = 1'b1;
        tick();
        tready = 1'b0;
        n_tests++;
        if (tvalid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_end: valid=%b done=%b busy=%b, expected 0 1 0",
                     tvalid, done, busy);
        end
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        n_tests++;
        if (tvalid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_early_start: valid=%b done=%b, expected 0 0", tvalid, done);
        end
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        n_tests++;
        if (tvalid !== 1'b1 || tdata !== 18'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_restart: valid=%b data=%0d busy=%b, expected 1 0 1",
                     tvalid, tdata, busy);
        end
    endtask

    task automatic test_carry();
        do_reset();
        tready = 1'b1;
        start_sweep(18'h3FF00, 18'h3FFFF, 18'h00200, 16'd1, 1'b0);
        n_tests++;
        if (tvalid !== 1'b1 || tdata !== 18'd0 || tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_beat: valid=%b data=%h last=%b, expected 1 0 1",
                     tvalid, tdata, tlast);
        end
        tick();
        n_tests++;
        if (tvalid !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_end: valid=%b done=%b, expected 0 1", tvalid, done);
        end
        do_reset();
        tready = 1'b1;
        start_sweep(18'd500, 18'd100, 18'd10, 16'd0, 1'b0);
        n_tests++;
        if (tvalid !== 1'b1 || tdata !== 18'd0 || tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL degen_beat: valid=%b data=%0d last=%b, expected 1 0 1",
                     tvalid, tdata, tlast);
        end
        tick();
        n_tests++;
        if (tvalid !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL degen_end: valid=%b done=%b, expected 0 1", tvalid, done);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tready = 1'b1;
        start_sweep(18'd1000, 18'd3000, 18'd1000, 16'd2, 1'b0);
        tick();
        tick();
        n_tests++;
        if (tvalid !== 1'b1 || tdata !== 18'd2000) begin
            n_fail++;
            $display("FAIL rstmid_pre: valid=%b data=%0d, expected 1 2000", tvalid, tdata);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 18'd0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid: valid=%b last=%b data=%0d busy=%b done=%b, expected all 0",
                     tvalid, tlast, tdata, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_wrap();
        test_backpressure();
        test_continuous();
        test_abort();
        test_carry();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
